// File: rtl/tdp18k_fifo_wr_arb_pkg.sv
// Shared types and helpers for the TDP18K FIFO write-port arbiter.
package tdp18k_arb_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd1,
        RECOVER = 2'd2
    } arb_state_t;

    localparam int DATA_W_DEF = 18;

    // Width of a requester id; never narrower than one bit.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tdp18k_fifo_wr_arb_rr_pick.sv
// Combinational round-robin selector: first valid requester at or after ptr.
module rr_pick
    import tdp18k_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    // Pick the valid requester with the smallest wrap-around distance from ptr.
    always_comb begin : pick
        int unsigned p;
        int unsigned d;
        int unsigned best;
        p     = 32'(ptr);
        d     = 0;
        best  = N;
        idx   = '0;
        grant = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (valid[k]) begin
                d = (k >= p) ? (k - p) : (k + N - p);
                if (d < best) begin
                    best = d;
                    idx  = IW'(k);
                end
            end
        end
        for (int unsigned k = 0; k < N; k++) begin
            grant[k] = (best < N) && (idx == IW'(k));
        end
    end

endmodule

// File: rtl/tdp18k_fifo_wr_arb.sv
// Write-port arbiter for one TDP18K FIFO: round-robin bursts, full-flag
// throttling and a flush/recover sequence.
module tdp18k_fifo_wr_arb
    import tdp18k_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int MAX_BURST   = 4,
    parameter int FLUSH_CYC   = 4,
    parameter int RECOVER_CYC = 3
) (
    input  logic                        CLK_i,
    input  logic                        RST_i,
    input  logic [NUM_REQ-1:0]          REQ_VALID_i,
    input  logic [NUM_REQ*DATA_W-1:0]   REQ_DATA_i,
    output logic [NUM_REQ-1:0]          REQ_READY_o,
    input  logic                        FLUSH_REQ_i,
    output logic                        FLUSH_DONE_o,
    input  logic                        FULL_i,
    input  logic                        FMO_i,
    output logic                        WEN_o,
    output logic [DATA_W-1:0]           WDATA_o,
    output logic                        FLUSH_no,
    output logic [id_w(NUM_REQ)-1:0]    GRANT_ID_o
);

    localparam int ID_W  = id_w(NUM_REQ);
    localparam int CNT_W = $clog2(max3(FLUSH_CYC, RECOVER_CYC, MAX_BURST) + 1);

    arb_state_t          state_q, state_d;
    logic [CNT_W-1:0]    seq_q, seq_d;
    logic [CNT_W-1:0]    burst_q, burst_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic                done_d;
    logic                stall;
    logic                grant_en;
    logic                accept;
    logic [NUM_REQ-1:0]  pick_oh;
    logic [ID_W-1:0]     pick_idx;
    logic [DATA_W-1:0]   pick_data;
    logic [CNT_W-1:0]    beats;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_pick (
        .valid (REQ_VALID_i),
        .ptr   (ptr_q),
        .grant (pick_oh),
        .idx   (pick_idx)
    );

    // Flush sequencer: RUN -> FLUSH (FLUSH_CYC) -> RECOVER (RECOVER_CYC) -> RUN.
    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        done_d  = 1'b0;
        unique case (state_q)
            RUN: begin
                if (FLUSH_REQ_i) begin
                    state_d = FLUSH;
                    seq_d   = '0;
                end
            end
            FLUSH: begin
                if (seq_q == CNT_W'(FLUSH_CYC - 1)) begin
                    state_d = RECOVER;
                    seq_d   = '0;
                end else begin
                    seq_d = seq_q + CNT_W'(1);
                end
            end
            RECOVER: begin
                if (seq_q == CNT_W'(RECOVER_CYC - 1)) begin
                    state_d = RUN;
                    seq_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    seq_d = seq_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = RUN;
                seq_d   = '0;
            end
        endcase
    end

    // Grant gating: flags lag one write, so an in-flight write with FMO set fills the FIFO.
    always_comb begin
        stall       = FULL_i | (FMO_i & WEN_o);
        grant_en    = (state_q == RUN) & ~FLUSH_REQ_i & ~stall;
        REQ_READY_o = grant_en ? pick_oh : '0;
        accept      = |(REQ_VALID_i & REQ_READY_o);
    end

    // Data mux for the selected requester.
    always_comb begin
        pick_data = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (pick_oh[k]) begin
                pick_data = REQ_DATA_i[k*DATA_W +: DATA_W];
            end
        end
    end

    // Burst tracking; a grant away from ptr restarts the count, so a dropped
    // holder is skipped in the same cycle rather than costing an idle cycle.
    always_comb begin
        ptr_d   = ptr_q;
        burst_d = burst_q;
        beats   = (pick_idx == ptr_q) ? (burst_q + CNT_W'(1)) : CNT_W'(1);
        if (accept) begin
            if (beats == CNT_W'(MAX_BURST)) begin
                ptr_d   = (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : (pick_idx + ID_W'(1));
                burst_d = '0;
            end else begin
                ptr_d   = pick_idx;
                burst_d = beats;
            end
        end
    end

    // State, counters and registered FIFO-side outputs.
    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            state_q      <= RUN;
            seq_q        <= '0;
            burst_q      <= '0;
            ptr_q        <= '0;
            WEN_o        <= 1'b0;
            WDATA_o      <= '0;
            FLUSH_no     <= 1'b1;
            FLUSH_DONE_o <= 1'b0;
            GRANT_ID_o   <= '0;
        end else begin
            state_q      <= state_d;
            seq_q        <= seq_d;
            burst_q      <= burst_d;
            ptr_q        <= ptr_d;
            WEN_o        <= accept;
            FLUSH_no     <= (state_d != FLUSH);
            FLUSH_DONE_o <= done_d;
            if (accept) begin
                WDATA_o    <= pick_data;
                GRANT_ID_o <= pick_idx;
            end
        end
    end

endmodule

// File: tb/tb_tdp18k_fifo_wr_arb.sv
// Directed and randomized checks for tdp18k_fifo_wr_arb.
module tb_tdp18k_fifo_wr_arb;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 18;
    localparam int ID_W    = 2;
    localparam int BOUND   = (NUM_REQ - 1) * 4;

    logic                      CLK_i = 1'b0;
    logic                      RST_i;
    logic [NUM_REQ-1:0]        REQ_VALID_i;
    logic [NUM_REQ*DATA_W-1:0] REQ_DATA_i;
    logic [NUM_REQ-1:0]        REQ_READY_o;
    logic                      FLUSH_REQ_i;
    logic                      FLUSH_DONE_o;
    logic                      FULL_i;
    logic                      FMO_i;
    logic                      WEN_o;
    logic [DATA_W-1:0]         WDATA_o;
    logic                      FLUSH_no;
    logic [ID_W-1:0]           GRANT_ID_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    tdp18k_fifo_wr_arb #(
        .NUM_REQ     (NUM_REQ),
        .DATA_W      (DATA_W),
        .MAX_BURST   (4),
        .FLUSH_CYC   (4),
        .RECOVER_CYC (3)
    ) dut (
        .CLK_i        (CLK_i),
        .RST_i        (RST_i),
        .REQ_VALID_i  (REQ_VALID_i),
        .REQ_DATA_i   (REQ_DATA_i),
        .REQ_READY_o  (REQ_READY_o),
        .FLUSH_REQ_i  (FLUSH_REQ_i),
        .FLUSH_DONE_o (FLUSH_DONE_o),
        .FULL_i       (FULL_i),
        .FMO_i        (FMO_i),
        .WEN_o        (WEN_o),
        .WDATA_o      (WDATA_o),
        .FLUSH_no     (FLUSH_no),
        .GRANT_ID_o   (GRANT_ID_o)
    );

    always #5 CLK_i = ~CLK_i;

    function automatic logic [DATA_W-1:0] dat(input int k, input int c);
        return DATA_W'((k << 12) | (c & 32'hfff));
    endfunction

    task automatic set_data();
        for (int k = 0; k < NUM_REQ; k++) begin
            REQ_DATA_i[k*DATA_W +: DATA_W] = dat(k, cyc);
        end
    endtask

    task automatic step();
        @(posedge CLK_i);
        #1;
        cyc++;
        set_data();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int g;
        int c0;
        logic [DATA_W-1:0] last;
        logic [NUM_REQ-1:0] v;
        logic [NUM_REQ-1:0] acc;
        logic prev_full;
        int wait_cnt [NUM_REQ];

        RST_i       = 1'b1;
        REQ_VALID_i = '0;
        FLUSH_REQ_i = 1'b0;
        FULL_i      = 1'b0;
        FMO_i       = 1'b0;
        set_data();
        #12;
        chk("rst_ready", 32'(REQ_READY_o), 0);
        chk("rst_wen",   32'(WEN_o), 0);
        chk("rst_wdata", 32'(WDATA_o), 0);
        chk("rst_flush", 32'(FLUSH_no), 1);
        chk("rst_done",  32'(FLUSH_DONE_o), 0);
        chk("rst_gid",   32'(GRANT_ID_o), 0);

        // All requesters valid: bursts of four in id order.
        @(negedge CLK_i);
        RST_i       = 1'b0;
        REQ_VALID_i = '1;
        cyc         = 0;
        set_data();
        for (int c = 0; c < 16; c++) begin
            g = (c / 4) % 4;
            #1 chk("t1_ready", 32'(REQ_READY_o), 32'(1 << g));
            c0 = cyc;
            step();
            chk("t1_wen",  32'(WEN_o), 1);
            chk("t1_data", 32'(WDATA_o), 32'(dat(g, c0)));
            chk("t1_gid",  32'(GRANT_ID_o), 32'(g));
        end

        // Lone requester 2: ten beats back to back.
        REQ_VALID_i = 4'b0100;
        last = '0;
        for (int c = 0; c < 10; c++) begin
            #1 chk("t2_ready", 32'(REQ_READY_o), 32'h4);
            c0 = cyc;
            last = dat(2, c0);
            step();
            chk("t2_wen",  32'(WEN_o), 1);
            chk("t2_data", 32'(WDATA_o), 32'(last));
            chk("t2_gid",  32'(GRANT_ID_o), 2);
        end
        REQ_VALID_i = '0;
        #1 chk("t2_idle_ready", 32'(REQ_READY_o), 0);
        step();
        chk("t2_idle_wen",  32'(WEN_o), 0);
        chk("t2_hold_data", 32'(WDATA_o), 32'(last));

        // Stalls: requester 2 holds ptr with two beats done.
        REQ_VALID_i = '1;
        #1 chk("t3_pre_ready", 32'(REQ_READY_o), 32'h4);
        step();
        chk("t3_pre_wen", 32'(WEN_o), 1);
        FMO_i = 1'b1;
        #1 chk("t3_fmo_ready", 32'(REQ_READY_o), 0);
        step();
        chk("t3_fmo_wen", 32'(WEN_o), 0);
        FMO_i  = 1'b0;
        FULL_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1 chk("t3_full_ready", 32'(REQ_READY_o), 0);
            step();
            chk("t3_full_wen", 32'(WEN_o), 0);
        end
        FULL_i = 1'b0;
        FMO_i  = 1'b1;
        #1 chk("t3_resume_ready", 32'(REQ_READY_o), 32'h4);
        step();
        chk("t3_resume_wen", 32'(WEN_o), 1);
        chk("t3_resume_gid", 32'(GRANT_ID_o), 2);
        #1 chk("t3_fmo2_ready", 32'(REQ_READY_o), 0);
        step();
        chk("t3_fmo2_wen", 32'(WEN_o), 0);
        FMO_i = 1'b0;
        #1 chk("t3_rotate_ready", 32'(REQ_READY_o), 32'h8);
        step();
        chk("t3_rotate_gid", 32'(GRANT_ID_o), 3);

        // Flush pulse mid-burst of requester 3.
        #1 chk("t4_pre_ready", 32'(REQ_READY_o), 32'h8);
        step();
        chk("t4_pre_wen", 32'(WEN_o), 1);
        FLUSH_REQ_i = 1'b1;
        #1 chk("t4_req_ready", 32'(REQ_READY_o), 0);
        chk("t4_inflight_wen", 32'(WEN_o), 1);
        step();
        FLUSH_REQ_i = 1'b0;
        chk("t4_flush_lo", 32'(FLUSH_no), 0);
        chk("t4_flush_wen", 32'(WEN_o), 0);
        for (int c = 0; c < 3; c++) begin
            #1 chk("t4_flush_ready", 32'(REQ_READY_o), 0);
            step();
            chk("t4_flush_lo", 32'(FLUSH_no), 0);
        end
        for (int c = 0; c < 3; c++) begin
            #1 chk("t4_rec_ready", 32'(REQ_READY_o), 0);
            step();
            chk("t4_rec_flush", 32'(FLUSH_no), 1);
            chk("t4_rec_done", 32'(FLUSH_DONE_o), 0);
        end
        #1 chk("t4_rec_last_ready", 32'(REQ_READY_o), 0);
        step();
        chk("t4_done", 32'(FLUSH_DONE_o), 1);
        chk("t4_done_flush", 32'(FLUSH_no), 1);
        #1 chk("t4_resume_ready", 32'(REQ_READY_o), 32'h8);
        step();
        chk("t4_done_clear", 32'(FLUSH_DONE_o), 0);
        chk("t4_resume_wen", 32'(WEN_o), 1);
        chk("t4_resume_gid", 32'(GRANT_ID_o), 3);

        // Held flush request re-flushes, then reset lands mid-FLUSH.
        FLUSH_REQ_i = 1'b1;
        for (int c = 0; c < 8; c++) step();
        chk("t5_done", 32'(FLUSH_DONE_o), 1);
        chk("t5_done_flush", 32'(FLUSH_no), 1);
        #1 chk("t5_rerun_ready", 32'(REQ_READY_o), 0);
        step();
        chk("t5_reflush", 32'(FLUSH_no), 0);
        chk("t5_done_clear", 32'(FLUSH_DONE_o), 0);
        step();
        #2 RST_i = 1'b1;
        #1;
        chk("t5_rst_flush", 32'(FLUSH_no), 1);
        chk("t5_rst_wen",   32'(WEN_o), 0);
        chk("t5_rst_wdata", 32'(WDATA_o), 0);
        chk("t5_rst_gid",   32'(GRANT_ID_o), 0);
        chk("t5_rst_ready", 32'(REQ_READY_o), 0);
        FLUSH_REQ_i = 1'b0;
        @(negedge CLK_i);
        RST_i = 1'b0;
        #1 chk("t5_first_ready", 32'(REQ_READY_o), 32'h1);
        step();
        chk("t5_first_gid", 32'(GRANT_ID_o), 0);
        chk("t5_first_wen", 32'(WEN_o), 1);

        // Random traffic with sticky valids: one-hot, full throttle, starvation bound.
        v = '0;
        prev_full = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) wait_cnt[k] = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!v[k]) v[k] = ($urandom_range(0, 2) == 0);
            end
            REQ_VALID_i = v;
            FULL_i = ($urandom_range(0, 9) == 0);
            FMO_i  = ($urandom_range(0, 9) == 0);
            #1;
            if (prev_full) chk("t6_full_wen", 32'(WEN_o), 0);
            acc = REQ_READY_o & v;
            chk("t6_onehot", 32'($onehot0(REQ_READY_o)), 1);
            if (FULL_i) chk("t6_full_ready", 32'(REQ_READY_o), 0);
            for (int k = 0; k < NUM_REQ; k++) begin
                if (acc[k]) begin
                    chk("t6_starve", 32'(wait_cnt[k] <= BOUND), 1);
                    wait_cnt[k] = 0;
                    v[k] = 1'($urandom_range(0, 1));
                end else if (v[k] && (acc != '0)) begin
                    wait_cnt[k]++;
                end
            end
            prev_full = FULL_i;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
